freq_meter_bcd: RTL and testbench

- Measures the frequency of an external pulse or clock-like signal by counting its rising edges during a fixed gate window of mclk cycles.
- Reports each result as a 4-digit packed BCD value, ready to drive the 7-segment display path.
- It is the measuring end of the divider chain: the divider produces ticks, and this block counts them.
- Sits between the divider/tick sources (or an external pin) and the segment display mux.

---
 rtl/freq_meter_bcd.sv | 161 ++++++++++++++++
 tb/tb_freq_meter_bcd.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter_bcd.sv
// Counts rising edges of an asynchronous input over a fixed window of mclk
// cycles and publishes each window's count as saturating 4-digit packed BCD.
module freq_meter_bcd #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 24
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        en,
  input  logic        sig_in,
  output logic [15:0] bcd,
  output logic        ovf,
  output logic        valid,
  output logic        busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MEAS = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);

  state_t            state_q, state_d;
  logic              s1_q, s2_q, s3_q;
  logic [CNT_W-1:0]  gate_q, gate_d;
  logic [15:0]       acc_q, acc_d;
  logic              acc_ovf_q, acc_ovf_d;
  logic [15:0]       bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;

  logic              edge_det;
  logic              last_cycle;
  logic              acc_full;
  logic              carry;
  logic [15:0]       acc_inc;
  logic [15:0]       acc_next;
  logic              ovf_next;

  assign edge_det   = s2_q & ~s3_q;
  assign last_cycle = (state_q == S_MEAS) && (gate_q == GATE_LAST);
  assign acc_full   = (acc_q == 16'h9999);

  // Ripple a +1 through the four BCD digits; each 9 wraps to 0 and carries.
  always_comb begin
    acc_inc = acc_q;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (acc_q[4*i +: 4] == 4'd9) begin
          acc_inc[4*i +: 4] = 4'd0;
        end else begin
          acc_inc[4*i +: 4] = acc_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  // Value including this cycle's edge; pins at 9999 and flags overflow instead of wrapping.
  always_comb begin
    acc_next = acc_q;
    ovf_next = acc_ovf_q;
    if (edge_det) begin
      if (acc_full) begin
        ovf_next = 1'b1;
      end else begin
        acc_next = acc_inc;
      end
    end
  end

  // State register
  always_ff @(posedge mclk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_MEAS;
      end
      S_MEAS: begin
        if (!en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy  = (state_q == S_MEAS);
    bcd   = bcd_q;
    ovf   = ovf_q;
    valid = valid_q;
  end

  // Datapath next values: window counter, accumulator and published result.
  always_comb begin
    gate_d    = gate_q;
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    if (state_q == S_MEAS) begin
      if (last_cycle) begin
        bcd_d     = acc_next;
        ovf_d     = ovf_next;
        valid_d   = 1'b1;
        gate_d    = '0;
        acc_d     = '0;
        acc_ovf_d = 1'b0;
      end else if (!en) begin
        gate_d    = '0;
        acc_d     = '0;
        acc_ovf_d = 1'b0;
      end else begin
        gate_d    = gate_q + CNT_W'(1);
        acc_d     = acc_next;
        acc_ovf_d = ovf_next;
      end
    end else begin
      gate_d    = '0;
      acc_d     = '0;
      acc_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge mclk) begin
    if (!rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      gate_q    <= '0;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      s1_q      <= sig_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      gate_q    <= gate_d;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_freq_meter_bcd.sv
// Bench for freq_meter_bcd: three instances with short, medium and long windows
// share one stimulus pin; results are checked against an expected-result queue.
module tb_freq_meter_bcd;

  logic        mclk = 1'b0;
  logic        rst;
  logic        sig_in;
  logic        en_i    [3];
  logic [15:0] bcd_o   [3];
  logic        ovf_o   [3];
  logic        valid_o [3];
  logic        busy_o  [3];

  logic [16:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int sel = 0;
  int valid_cnt [3];
  int last_vcyc [3];
  int prev_vcyc [3];
  int bcd_sum   [3];

  int gen_per = 0;
  int gen_hi = 0;
  int gen_ph = 0;
  int gen_left = 0;

  freq_meter_bcd #(.GATE_CYCLES(100), .CNT_W(24)) dut_short (
    .mclk(mclk), .rst(rst), .en(en_i[0]), .sig_in(sig_in),
    .bcd(bcd_o[0]), .ovf(ovf_o[0]), .valid(valid_o[0]), .busy(busy_o[0])
  );

  freq_meter_bcd #(.GATE_CYCLES(1000), .CNT_W(24)) dut_mid (
    .mclk(mclk), .rst(rst), .en(en_i[1]), .sig_in(sig_in),
    .bcd(bcd_o[1]), .ovf(ovf_o[1]), .valid(valid_o[1]), .busy(busy_o[1])
  );

  freq_meter_bcd #(.GATE_CYCLES(25000), .CNT_W(24)) dut_long (
    .mclk(mclk), .rst(rst), .en(en_i[2]), .sig_in(sig_in),
    .bcd(bcd_o[2]), .ovf(ovf_o[2]), .valid(valid_o[2]), .busy(busy_o[2])
  );

  // Clock / cycle counter
  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;

  function automatic int bcd2int(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // Scoreboard: every valid pulse pops one expected {ovf, bcd}
  always @(negedge mclk) begin
    for (int i = 0; i < 3; i++) begin
      if (valid_o[i] === 1'b1) begin
        logic [16:0] exp_v;
        valid_cnt[i]++;
        prev_vcyc[i] = last_vcyc[i];
        last_vcyc[i] = cyc;
        bcd_sum[i] += bcd2int(bcd_o[i]);
        checks++;
        if (i != sel || exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid dut=%0d bcd=%h ovf=%b", i, bcd_o[i], ovf_o[i]);
        end else begin
          exp_v = exp_q.pop_front();
          if ({ovf_o[i], bcd_o[i]} !== exp_v) begin
            failures++;
            $display("FAIL result dut=%0d got ovf=%b bcd=%h expected ovf=%b bcd=%h",
                     i, ovf_o[i], bcd_o[i], exp_v[16], exp_v[15:0]);
          end
        end
      end
    end
  end

  // Driver: advance one cycle and drive sig_in from the pattern generator
  task automatic tick();
    @(posedge mclk);
    #1;
    if (gen_per == 0 || gen_left == 0) begin
      sig_in = 1'b0;
    end else begin
      if (gen_ph == 0 && gen_left > 0) gen_left--;
      sig_in = (gen_ph < gen_hi);
      gen_ph = (gen_ph + 1 >= gen_per) ? 0 : gen_ph + 1;
    end
  endtask

  // First rise of the pattern and the en rise happen after the same clock edge
  task automatic start_window(input int idx, input int per, input int hi, input int left);
    gen_per  = per;
    gen_hi   = hi;
    gen_ph   = 0;
    gen_left = left;
    sel      = idx;
    tick();
    en_i[idx] = 1'b1;
  endtask

  task automatic stop_meas(input int idx);
    en_i[idx] = 1'b0;
    gen_per   = 0;
    repeat (8) tick();
  endtask

  task automatic wait_valid(input int idx, input int target, input int budget);
    int n = 0;
    while (valid_cnt[idx] < target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (valid_cnt[idx] < target) begin
      failures++;
      $display("FAIL valid_timeout dut=%0d got_count=%0d expected_count=%0d", idx, valid_cnt[idx], target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) en_i[i] = 1'b1;
    gen_per = 2; gen_hi = 1; gen_ph = 0; gen_left = -1;
    repeat (5) tick();
    for (int i = 0; i < 3; i++) begin
      checks += 4;
      if (bcd_o[i] !== 16'h0000) begin failures++; $display("FAIL reset_bcd dut=%0d got=%h expected=0000", i, bcd_o[i]); end
      if (ovf_o[i] !== 1'b0) begin failures++; $display("FAIL reset_ovf dut=%0d got=%b expected=0", i, ovf_o[i]); end
      if (valid_o[i] !== 1'b0) begin failures++; $display("FAIL reset_valid dut=%0d got=%b expected=0", i, valid_o[i]); end
      if (busy_o[i] !== 1'b0) begin failures++; $display("FAIL reset_busy dut=%0d got=%b expected=0", i, busy_o[i]); end
    end
    rst = 1'b1;
    en_i[1] = 1'b0;
    en_i[2] = 1'b0;
    sel = 0;
    repeat (100) tick();
    checks += 2;
    if (valid_cnt[0] !== 0) begin failures++; $display("FAIL early_valid got=%0d expected=0", valid_cnt[0]); end
    if (busy_o[0] !== 1'b1) begin failures++; $display("FAIL busy_after_reset got=%b expected=1", busy_o[0]); end
    exp_q.push_back({1'b0, 16'h0050});
    wait_valid(0, 1, 10);
    stop_meas(0);
  endtask

  task automatic test_basic_count();
    int base = valid_cnt[0];
    start_window(0, 10, 5, -1);
    repeat (3) exp_q.push_back({1'b0, 16'h0010});
    wait_valid(0, base + 1, 200);
    wait_valid(0, base + 2, 200);
    checks++;
    if (last_vcyc[0] - prev_vcyc[0] !== 100) begin failures++; $display("FAIL valid_spacing got=%0d expected=100", last_vcyc[0] - prev_vcyc[0]); end
    wait_valid(0, base + 3, 200);
    checks++;
    if (last_vcyc[0] - prev_vcyc[0] !== 100) begin failures++; $display("FAIL valid_spacing2 got=%0d expected=100", last_vcyc[0] - prev_vcyc[0]); end
    stop_meas(0);
  endtask

  task automatic test_abort();
    int base = valid_cnt[0];
    int held;
    start_window(0, 10, 5, -1);
    exp_q.push_back({1'b0, 16'h0010});
    wait_valid(0, base + 1, 200);
    repeat (49) tick();
    checks++;
    if (busy_o[0] !== 1'b1) begin failures++; $display("FAIL busy_mid_window got=%b expected=1", busy_o[0]); end
    en_i[0] = 1'b0;
    tick();
    checks++;
    if (busy_o[0] !== 1'b0) begin failures++; $display("FAIL busy_after_abort got=%b expected=0", busy_o[0]); end
    held = valid_cnt[0];
    repeat (150) tick();
    checks += 3;
    if (valid_cnt[0] !== held) begin failures++; $display("FAIL abort_valid got=%0d expected=%0d", valid_cnt[0], held); end
    if (bcd_o[0] !== 16'h0010) begin failures++; $display("FAIL abort_bcd_hold got=%h expected=0010", bcd_o[0]); end
    if (ovf_o[0] !== 1'b0) begin failures++; $display("FAIL abort_ovf_hold got=%b expected=0", ovf_o[0]); end
    gen_per = 0;
    repeat (8) tick();
    start_window(0, 20, 10, -1);
    exp_q.push_back({1'b0, 16'h0005});
    wait_valid(0, held + 1, 200);
    stop_meas(0);
  endtask

  task automatic test_bcd_carry();
    int base = valid_cnt[1];
    start_window(1, 9, 4, -1);
    exp_q.push_back({1'b0, 16'h0111});
    wait_valid(1, base + 1, 1100);
    stop_meas(1);
    start_window(1, 9, 4, 109);
    exp_q.push_back({1'b0, 16'h0109});
    wait_valid(1, base + 2, 1100);
    stop_meas(1);
  endtask

  task automatic test_saturation();
    int base = valid_cnt[2];
    start_window(2, 2, 1, -1);
    exp_q.push_back({1'b1, 16'h9999});
    exp_q.push_back({1'b0, 16'h2500});
    // Switch pattern so the first period-10 rise lands in the second window
    repeat (24999) tick();
    gen_per = 10; gen_hi = 5; gen_ph = 0; gen_left = -1;
    wait_valid(2, base + 2, 25200);
    checks++;
    if (last_vcyc[2] - prev_vcyc[2] !== 25000) begin failures++; $display("FAIL long_spacing got=%0d expected=25000", last_vcyc[2] - prev_vcyc[2]); end
    stop_meas(2);
  endtask

  task automatic test_back_to_back();
    int base = valid_cnt[0];
    start_window(0, 0, 0, 0);
    bcd_sum[0] = 0;
    exp_q.push_back({1'b0, 16'h0002});
    exp_q.push_back({1'b0, 16'h0001});
    exp_q.push_back({1'b0, 16'h0002});
    for (int k = 1; k <= 301; k++) begin
      tick();
      if (k == 10 || k == 98 || k == 120 || k == 199 || k == 250) sig_in = 1'b1;
    end
    wait_valid(0, base + 3, 20);
    stop_meas(0);
    checks++;
    if (bcd_sum[0] !== 5) begin failures++; $display("FAIL edge_total got=%0d expected=5", bcd_sum[0]); end
  endtask

  initial begin
    rst = 1'b0;
    sig_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en_i[i] = 1'b0;
      valid_cnt[i] = 0;
      last_vcyc[i] = 0;
      prev_vcyc[i] = 0;
      bcd_sum[i] = 0;
    end
    test_reset();
    test_basic_count();
    test_abort();
    test_bcd_carry();
    test_saturation();
    test_back_to_back();
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL leftover_expected got=%0d expected=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
